uart_cmd_parser: RTL and testbench

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/uart_cmd_parser.sv | 113 +++++++++++
 tb/tb_uart_cmd_parser.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// Byte-stream command parser: frames SYNC, OP, ADDR, DATA, CSUM (XOR) into
// one command handshake, with an inter-byte timeout and saturating error counters.
module uart_cmd_parser #(
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_data_valid,
   output logic       rx_data_ready,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic [7:0] cmd_op,
   output logic [7:0] cmd_addr,
   output logic [7:0] cmd_data,
   input  logic       clr_cnt,
   output logic [7:0] csum_err_cnt,
   output logic [7:0] tmo_err_cnt,
   output logic       err_pulse
);

   typedef enum logic [2:0] {
      IDLE,
      GET_OP,
      GET_ADDR,
      GET_DATA,
      GET_CSUM,
      ISSUE
   } state_t;

   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [7:0]  op_q, addr_q, data_q;
   logic [31:0] tmo_cnt_q;
   logic        accept, in_get, tmo_hit, csum_err;

   assign accept   = rx_data_valid & rx_data_ready;
   assign in_get   = (state_q == GET_OP) || (state_q == GET_ADDR) ||
                     (state_q == GET_DATA) || (state_q == GET_CSUM);
   // An accepted byte always beats a timeout landing in the same cycle.
   assign tmo_hit  = in_get & ~accept & (tmo_cnt_q == TMO_LAST);
   assign csum_err = (state_q == GET_CSUM) & accept &
                     (rx_data != (op_q ^ addr_q ^ data_q));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; asynchronous reset is in the sensitivity list.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // NOTE: state_d gets a default before the case so no path infers a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (accept && rx_data == SYNC_BYTE) state_d = GET_OP;
         GET_OP:   if (accept) state_d = GET_ADDR;
                   else if (tmo_hit) state_d = IDLE;
         GET_ADDR: if (accept) state_d = GET_DATA;
                   else if (tmo_hit) state_d = IDLE;
         GET_DATA: if (accept) state_d = GET_CSUM;
                   else if (tmo_hit) state_d = IDLE;
         GET_CSUM: if (accept) state_d = csum_err ? IDLE : ISSUE;
                   else if (tmo_hit) state_d = IDLE;
         ISSUE:    if (cmd_ready) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      rx_data_ready = (state_q != ISSUE);
      cmd_valid     = (state_q == ISSUE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q      <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         tmo_cnt_q <= '0;
      end else begin
         if (accept && state_q == GET_OP)   op_q   <= rx_data;
         if (accept && state_q == GET_ADDR) addr_q <= rx_data;
         if (accept && state_q == GET_DATA) data_q <= rx_data;
         if (accept || !in_get || tmo_hit) tmo_cnt_q <= '0;
         else                              tmo_cnt_q <= tmo_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum_err_cnt <= '0;
         tmo_err_cnt  <= '0;
         err_pulse    <= 1'b0;
      end else begin
         err_pulse <= csum_err | tmo_hit;
         if (clr_cnt) begin
            csum_err_cnt <= '0;
            tmo_err_cnt  <= '0;
         end else begin
            if (csum_err && csum_err_cnt != 8'hFF) csum_err_cnt <= csum_err_cnt + 8'd1;
            if (tmo_hit && tmo_err_cnt != 8'hFF)   tmo_err_cnt  <= tmo_err_cnt + 8'd1;
         end
      end
   end

   assign cmd_op   = op_q;
   assign cmd_addr = addr_q;
   assign cmd_data = data_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: frame table plus hand-written timeout,
// backpressure, saturation, clear and reset sequences.
module tb_uart_cmd_parser;

   localparam int TMO = 100;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_data = '0;
   logic       rx_data_valid = 1'b0;
   logic       rx_data_ready;
   logic       cmd_valid;
   logic       cmd_ready = 1'b1;
   logic [7:0] cmd_op, cmd_addr, cmd_data;
   logic       clr_cnt = 1'b0;
   logic [7:0] csum_err_cnt, tmo_err_cnt;
   logic       err_pulse;

   uart_cmd_parser #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
      .rx_data_ready(rx_data_ready), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .clr_cnt(clr_cnt),
      .csum_err_cnt(csum_err_cnt), .tmo_err_cnt(tmo_err_cnt), .err_pulse(err_pulse)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Handshake / error-strobe monitor, sampled on the falling edge.
   int         n_cmd = 0;
   int         n_err = 0;
   logic [7:0] last_op = '0, last_addr = '0, last_data = '0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (cmd_valid && cmd_ready) begin
            n_cmd++;
            last_op   = cmd_op;
            last_addr = cmd_addr;
            last_data = cmd_data;
         end
         if (err_pulse) n_err++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int exp_cmd = 0, exp_err = 0, exp_csum = 0, exp_tmo = 0;

   function automatic int sat(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      int waited = 0;
      @(negedge clk);
      rx_data       = b;
      rx_data_valid = 1'b1;
      while (!rx_data_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!rx_data_ready) begin
         tests++;
         fails++;
         $display("FAIL rx_ready_wait: got 0 expected 1");
      end
      @(posedge clk);
      #1 rx_data_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] op, input logic [7:0] addr,
                             input logic [7:0] data, input logic [7:0] cs);
      send_byte(8'hA5);
      send_byte(op);
      send_byte(addr);
      send_byte(data);
      send_byte(cs);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " reset outputs"},
            {cmd_valid, rx_data_ready, cmd_op, cmd_addr, cmd_data, csum_err_cnt, tmo_err_cnt, err_pulse},
            {1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0});
   endtask

   typedef struct {
      string       name;
      int          n;
      logic [63:0] bytes;
      int          n_cmd;
      logic [7:0]  op, addr, data;
      int          csum_inc;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input string name, input int n, input logic [63:0] bytes,
                          input int nc, input logic [7:0] op, input logic [7:0] addr,
                          input logic [7:0] data, input int ci);
      vec_t v;
      v.name = name; v.n = n; v.bytes = bytes; v.n_cmd = nc;
      v.op = op; v.addr = addr; v.data = data; v.csum_inc = ci;
      vecs.push_back(v);
   endtask

   initial begin
      add_vec("good_basic",  5, 64'hA501103C2D000000, 1, 8'h01, 8'h10, 8'h3C, 0);
      add_vec("bad_csum",    5, 64'hA502205500000000, 0, 8'h00, 8'h00, 8'h00, 1);
      add_vec("good_after",  5, 64'hA504400F4B000000, 1, 8'h04, 8'h40, 8'h0F, 0);
      add_vec("noise_sync",  7, 64'h00FFA503A5A50300, 1, 8'h03, 8'hA5, 8'hA5, 0);
      add_vec("all_sync",    5, 64'hA5A5A5A5A5000000, 1, 8'hA5, 8'hA5, 8'hA5, 0);
      add_vec("op_ff",       5, 64'hA5FF0000FF000000, 1, 8'hFF, 8'h00, 8'h00, 0);
      add_vec("noise_only",  2, 64'h1234000000000000, 0, 8'h00, 8'h00, 8'h00, 0);
      add_vec("bad_csum2",   5, 64'hA510203031000000, 0, 8'h00, 8'h00, 8'h00, 1);

      // Reset state, during and after reset.
      #1 check_reset_outputs("in_reset");
      idle(2);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk) check_reset_outputs("after_reset");

      // Frame table.
      foreach (vecs[i]) begin
         for (int k = 0; k < vecs[i].n; k++) send_byte(vecs[i].bytes[63 - 8*k -: 8]);
         exp_cmd  += vecs[i].n_cmd;
         exp_csum  = sat(exp_csum + vecs[i].csum_inc);
         exp_err  += vecs[i].csum_inc;
         idle(4);
         @(negedge clk);
         check({vecs[i].name, " cmd count"}, n_cmd, exp_cmd);
         if (vecs[i].n_cmd > 0)
            check({vecs[i].name, " op/addr/data"}, {last_op, last_addr, last_data},
                  {vecs[i].op, vecs[i].addr, vecs[i].data});
         check({vecs[i].name, " csum_err_cnt"}, csum_err_cnt, exp_csum);
         check({vecs[i].name, " err pulses"}, n_err, exp_err);
         check({vecs[i].name, " tmo_err_cnt"}, tmo_err_cnt, exp_tmo);
      end

      // Timeout: one cycle short of the limit nothing happens, the next cycle fires.
      send_byte(8'hA5);
      send_byte(8'h01);
      idle(TMO - 1);
      @(negedge clk);
      check("tmo before limit", {tmo_err_cnt, err_pulse}, {8'h00, 1'b0});
      @(posedge clk);
      @(negedge clk);
      exp_tmo = 1; exp_err++;
      check("tmo at limit", {tmo_err_cnt, err_pulse}, {8'h01, 1'b1});
      @(negedge clk);
      check("tmo pulse width", err_pulse, 1'b0);
      send_byte(8'h10);
      send_byte(8'h3C);
      send_byte(8'h2D);
      idle(3);
      @(negedge clk);
      check("tmo partial discarded", n_cmd, exp_cmd);

      // Byte on the final count cycle wins over the timeout.
      send_byte(8'hA5);
      send_byte(8'h01);
      idle(TMO - 1);
      send_byte(8'h10);
      send_byte(8'h3C);
      send_byte(8'h2D);
      idle(3);
      @(negedge clk);
      exp_cmd++;
      check("late byte cmd", {n_cmd, last_op, last_addr, last_data}, {exp_cmd, 8'h01, 8'h10, 8'h3C});
      check("late byte no tmo", {tmo_err_cnt, n_err}, {8'(exp_tmo), exp_err});

      // Backpressure: command held stable while cmd_ready is low.
      @(posedge clk);
      #1 cmd_ready = 1'b0;
      send_frame(8'h07, 8'h70, 8'h11, 8'h66);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check("hold", {cmd_valid, rx_data_ready, cmd_op, cmd_addr, cmd_data},
               {1'b1, 1'b0, 8'h07, 8'h70, 8'h11});
      end
      @(posedge clk);
      #1 cmd_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      exp_cmd++;
      check("release", {cmd_valid, rx_data_ready, n_cmd}, {1'b0, 1'b1, exp_cmd});

      // Saturation of the checksum counter.
      for (int f = 0; f < 300; f++) send_frame(8'h00, 8'h00, 8'h00, 8'h01);
      exp_csum = sat(exp_csum + 300);
      @(negedge clk);
      check("csum saturated", csum_err_cnt, exp_csum);
      send_frame(8'h00, 8'h00, 8'h00, 8'h01);
      @(negedge clk);
      check("csum stays FF", csum_err_cnt, 8'hFF);

      @(negedge clk) clr_cnt = 1'b1;
      @(posedge clk);
      #1 clr_cnt = 1'b0;
      @(negedge clk);
      check("clear both", {csum_err_cnt, tmo_err_cnt}, 16'h0000);

      // Clear wins over an increment in the same cycle.
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      @(negedge clk);
      rx_data = 8'h01; rx_data_valid = 1'b1; clr_cnt = 1'b1;
      @(posedge clk);
      #1 rx_data_valid = 1'b0; clr_cnt = 1'b0;
      @(negedge clk);
      check("clear beats incr", {csum_err_cnt, err_pulse}, {8'h00, 1'b1});

      // Reset mid-frame.
      send_frame(8'h00, 8'h00, 8'h00, 8'h01);
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h10);
      @(negedge clk) rst_n = 1'b0;
      #1 check_reset_outputs("mid_frame");
      @(negedge clk) rst_n = 1'b1;
      send_byte(8'h3C);
      send_byte(8'h2D);
      idle(3);
      @(negedge clk);
      check("mid_frame no cmd", {cmd_valid, n_cmd}, {1'b0, exp_cmd});

      // Reset while a command is pending.
      @(posedge clk);
      #1 cmd_ready = 1'b0;
      send_frame(8'h09, 8'h90, 8'h33, 8'hAA);
      @(negedge clk);
      check("issue before reset", cmd_valid, 1'b1);
      rst_n = 1'b0;
      #1 check_reset_outputs("in_issue");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1 cmd_ready = 1'b1;
      idle(3);
      @(negedge clk);
      check("issue dropped", {cmd_valid, n_cmd}, {1'b0, exp_cmd});

      send_frame(8'h5A, 8'h01, 8'h02, 8'h59);
      idle(3);
      @(negedge clk);
      exp_cmd++;
      check("post reset cmd", {n_cmd, last_op, last_addr, last_data}, {exp_cmd, 8'h5A, 8'h01, 8'h02});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
